// File: rtl/disp_pkg.sv
// Shared display types: scan FSM state encoding and anode polarity helpers.
// The segment decoder imports the same package so both agree on polarity.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam int NUM_DIGITS = 4;

  function automatic logic [3:0] anode_off(input logic active_low);
    return active_low ? 4'b1111 : 4'b0000;
  endfunction

  function automatic logic [3:0] anode_lit(input logic [1:0] idx, input logic active_low);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return active_low ? ~onehot : onehot;
  endfunction

endpackage

// File: rtl/rr_next4.sv
// Round-robin search over a 4-bit digit mask: returns the first enabled index
// after cur (wrapping), falling back to cur itself when it is the only one set.
module rr_next4 (
  input  logic [3:0] mask,
  input  logic [1:0] cur,
  output logic [1:0] nxt,
  output logic       valid
);

  logic [1:0] cand;

  always_comb begin
    nxt   = cur;
    valid = |mask;
    cand  = cur;
    // Walk offsets 4..1 so the smallest offset that hits is the last to win.
    for (int k = 4; k >= 1; k--) begin
      cand = cur + 2'(k);
      if (mask[cand]) nxt = cand;
    end
  end

endmodule

// File: rtl/scan_ctrl.sv
// Multiplexed 4-digit display scanner: each slot blanks all anodes, then lights
// the selected digit; o_ctrl feeds the registered data mux and moves only at slot start.
module scan_ctrl
  import disp_pkg::*;
#(
  parameter int PRESCALE         = 50000,
  parameter int BLANK            = 1000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [3:0] i_digit_en,
  output logic [1:0] o_ctrl,
  output logic [3:0] o_anode,
  output logic       o_slot_start,
  output logic [1:0] o_dbg_state
);

  localparam int            CW         = $clog2(PRESCALE);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] PRE_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [3:0]    ALL_OFF    = anode_off(ANODE_ACTIVE_LOW);

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [3:0]    anode_q, anode_d;
  logic          slot_q, slot_d;
  logic          en_q;
  logic          start_slot;
  logic [1:0]    rr_cur, rr_nxt;
  logic          rr_valid;

  // From IDLE, searching after digit 3 yields the lowest enabled digit.
  assign rr_cur = (state_q == ST_IDLE) ? 2'd3 : ctrl_q;

  rr_next4 u_rr (
    .mask  (i_digit_en),
    .cur   (rr_cur),
    .nxt   (rr_nxt),
    .valid (rr_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= 2'b00;
      anode_q <= ALL_OFF;
      slot_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      anode_q <= anode_d;
      slot_q  <= slot_d;
      en_q    <= i_en;
    end
  end

  // en_q doubles as the "was running last cycle" flag: it is 0 after reset, so
  // the first slot starts on the second edge, and 0 after a pause, so the held
  // digit restarts its blanking from a fresh count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl_d     = ctrl_q;
    anode_d    = ALL_OFF;
    slot_d     = 1'b0;
    start_slot = 1'b0;

    if (!i_en) begin
      state_d = state_q;
    end else if (!rr_valid) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_q) begin
            start_slot = 1'b1;
            ctrl_d     = rr_nxt;
          end
        end
        ST_BLANK, ST_SHOW: begin
          if (!en_q || !i_digit_en[ctrl_q]) begin
            start_slot = 1'b1;
            ctrl_d     = i_digit_en[ctrl_q] ? ctrl_q : rr_nxt;
          end else if (state_q == ST_BLANK) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == BLANK_LAST) begin
              state_d = ST_SHOW;
              anode_d = anode_lit(ctrl_q, ANODE_ACTIVE_LOW);
            end
          end else if (cnt_q == PRE_LAST) begin
            start_slot = 1'b1;
            ctrl_d     = rr_nxt;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            anode_d = anode_lit(ctrl_q, ANODE_ACTIVE_LOW);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (start_slot) begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        slot_d  = 1'b1;
      end
    end
  end

  assign o_ctrl       = ctrl_q;
  assign o_anode      = anode_q;
  assign o_slot_start = slot_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: directed scenarios plus random enable/mask traffic, checked
// cycle by cycle against a slot-position model for both anode polarities.
module tb_scan_ctrl;
  import disp_pkg::*;

  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_en = 1'b0;
  logic [3:0] i_digit_en = 4'b0000;

  logic [1:0] o_ctrl, o_ctrl_h;
  logic [3:0] o_anode, o_anode_h;
  logic       o_slot_start, o_slot_start_h;
  logic [1:0] o_dbg_state, o_dbg_state_h;

  always #5 clk = ~clk;

  scan_ctrl #(.PRESCALE(PRESCALE), .BLANK(BLANK), .ANODE_ACTIVE_LOW(1'b1)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (i_en),
    .i_digit_en   (i_digit_en),
    .o_ctrl       (o_ctrl),
    .o_anode      (o_anode),
    .o_slot_start (o_slot_start),
    .o_dbg_state  (o_dbg_state)
  );

  scan_ctrl #(.PRESCALE(PRESCALE), .BLANK(BLANK), .ANODE_ACTIVE_LOW(1'b0)) u_dut_hi (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (i_en),
    .i_digit_en   (i_digit_en),
    .o_ctrl       (o_ctrl_h),
    .o_anode      (o_anode_h),
    .o_slot_start (o_slot_start_h),
    .o_dbg_state  (o_dbg_state_h)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];   // {state[1:0], slot_start, ctrl[1:0], anode_active_low[3:0]}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A slot is a position 0..PRESCALE-1; positions below BLANK are dark.
  bit m_active;
  int m_pos;
  int m_dig;
  bit m_prev_en;
  bit m_slot;

  task automatic model_reset();
    m_active  = 1'b0;
    m_pos     = 0;
    m_dig     = 0;
    m_prev_en = 1'b0;
    m_slot    = 1'b0;
    exp_q.delete();
  endtask

  function automatic int lowest_enabled(input logic [3:0] mask);
    for (int k = 0; k < 4; k++) if (mask[k]) return k;
    return 0;
  endfunction

  function automatic int next_enabled(input logic [3:0] mask, input int d);
    for (int k = 1; k <= 4; k++) if (mask[(d + k) % 4]) return (d + k) % 4;
    return d;
  endfunction

  task automatic start_slot(input int d);
    m_active = 1'b1;
    m_dig    = d;
    m_pos    = 0;
    m_slot   = 1'b1;
  endtask

  task automatic model_edge(input logic en, input logic [3:0] mask);
    m_slot = 1'b0;
    if (!en) begin
      // frozen
    end else if (mask == 4'b0000) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (m_prev_en) start_slot(lowest_enabled(mask));
    end else if (!m_prev_en || !mask[m_dig]) begin
      start_slot(mask[m_dig] ? m_dig : next_enabled(mask, m_dig));
    end else begin
      m_pos++;
      if (m_pos == PRESCALE) start_slot(next_enabled(mask, m_dig));
    end
    m_prev_en = en;
  endtask

  function automatic logic [8:0] model_outputs(input logic en);
    logic [3:0] onehot;
    logic [3:0] anode;
    logic [1:0] st;
    onehot = 4'b0001 << m_dig;
    anode  = (en && m_active && m_pos >= BLANK) ? ~onehot : 4'b1111;
    if (!m_active)         st = ST_IDLE;
    else if (m_pos < BLANK) st = ST_BLANK;
    else                   st = ST_SHOW;
    return {st, m_slot, 2'(m_dig), anode};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic en, input logic [3:0] mask);
    logic [8:0] e;
    logic [3:0] exp_hi;
    i_en       = en;
    i_digit_en = mask;
    @(posedge clk);
    model_edge(en, mask);
    exp_q.push_back(model_outputs(en));
    @(negedge clk);
    e      = exp_q.pop_front();
    exp_hi = ~e[3:0];
    check("state",      o_dbg_state,    e[8:7]);
    check("slot_start", o_slot_start,   e[6]);
    check("ctrl",       o_ctrl,         e[5:4]);
    check("anode",      o_anode,        e[3:0]);
    check("anode_hi",   o_anode_h,      exp_hi);
    check("ctrl_hi",    o_ctrl_h,       e[5:4]);
    check("slot_hi",    o_slot_start_h, e[6]);
    check("state_hi",   o_dbg_state_h,  e[8:7]);
  endtask

  task automatic run_until(input int dig, input int pos, input logic [3:0] mask, output bit found);
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (m_active && m_dig == dig && m_pos == pos) begin
        found = 1'b1;
        return;
      end
      step(1'b1, mask);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] seq_q[$];
    logic [1:0] exp_seq[5];
    logic [3:0] mask;
    bit         found;

    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    model_reset();

    // Reset values, asserted without any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_anode",    o_anode,      4'b1111);
    check("rst_anode_hi", o_anode_h,    4'b0000);
    check("rst_ctrl",     o_ctrl,       2'b00);
    check("rst_slot",     o_slot_start, 1'b0);
    check("rst_state",    o_dbg_state,  ST_IDLE);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full mask: digits 0,1,2,3,0 in 8-cycle slots.
    for (int i = 0; i < 42; i++) begin
      step(1'b1, 4'b1111);
      if (o_slot_start) seq_q.push_back(o_ctrl);
    end
    check("seq_len", seq_q.size() >= 5, 1'b1);
    for (int i = 0; i < 5 && i < seq_q.size(); i++) check("seq_ctrl", seq_q[i], exp_seq[i]);

    // Sparse masks.
    for (int i = 0; i < 24; i++) step(1'b1, 4'b0101);
    for (int i = 0; i < 24; i++) step(1'b1, 4'b0100);

    // Pause on the 4th lit cycle of digit 1.
    run_until(1, BLANK + 3, 4'b1111, found);
    check("reach_pause_point", found, 1'b1);
    step(1'b0, 4'b1111);
    check("pause_anode", o_anode, 4'b1111);
    check("pause_ctrl",  o_ctrl,  2'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1111);
    step(1'b1, 4'b1111);
    check("resume_slot", o_slot_start, 1'b1);
    step(1'b1, 4'b1111);
    check("resume_blank", o_anode, 4'b1111);
    step(1'b1, 4'b1111);
    check("resume_lit", o_anode, 4'b1101);
    for (int i = 0; i < 8; i++) step(1'b1, 4'b1111);

    // Disable the lit digit 2, then clear the mask.
    run_until(2, BLANK, 4'b1111, found);
    check("reach_digit2", found, 1'b1);
    step(1'b1, 4'b1011);
    check("drop_slot",  o_slot_start, 1'b1);
    check("drop_ctrl",  o_ctrl,       2'd3);
    check("drop_anode", o_anode,      4'b1111);
    for (int i = 0; i < 5; i++) step(1'b1, 4'b1011);
    step(1'b1, 4'b0000);
    check("mask0_anode", o_anode,     4'b1111);
    check("mask0_state", o_dbg_state, ST_IDLE);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0000);
    for (int i = 0; i < 12; i++) step(1'b1, 4'b1111);

    // Asynchronous reset in the middle of a lit cycle.
    run_until(1, BLANK + 2, 4'b1111, found);
    check("reach_rst_point", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_anode",    o_anode,      4'b1111);
    check("arst_anode_hi", o_anode_h,    4'b0000);
    check("arst_ctrl",     o_ctrl,       2'b00);
    check("arst_slot",     o_slot_start, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'b1111);
    check("arst_edge1_slot", o_slot_start, 1'b0);
    step(1'b1, 4'b1111);
    check("arst_edge2_slot", o_slot_start, 1'b1);

    // Random enable / mask traffic.
    mask = 4'b1111;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom_range(0, 15));
      step($urandom_range(0, 9) != 0, mask);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
